// File: rtl/gate_logic_core.sv
// Bitwise seven-gate core. Define GATE_LOGIC_REG_OUT_EN for registered outputs
// (1-cycle latency, hold on idle); default build is purely combinational.
module gate_logic_core #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             in_valid,
   output logic [WIDTH-1:0] and_out,
   output logic [WIDTH-1:0] or_out,
   output logic [WIDTH-1:0] nand_out,
   output logic [WIDTH-1:0] nor_out,
   output logic [WIDTH-1:0] notb_out,
   output logic [WIDTH-1:0] xor_out,
   output logic [WIDTH-1:0] xnor_out,
   output logic             out_valid
);

   logic [WIDTH-1:0] and_p0, or_p0, nand_p0, nor_p0, notb_p0, xor_p0, xnor_p0;

   always_comb begin
      and_p0  = a & b;
      or_p0   = a | b;
      nand_p0 = ~(a & b);
      nor_p0  = ~(a | b);
      notb_p0 = ~b;
      xor_p0  = a ^ b;
      xnor_p0 = ~(a ^ b);
   end

`ifdef GATE_LOGIC_REG_OUT_EN
   logic [WIDTH-1:0] and_p1, or_p1, nand_p1, nor_p1, notb_p1, xor_p1, xnor_p1;
   logic             vld_p1;

   // p0 -> p1: results load only on valid edges and otherwise hold; reset
   // clears the whole stage, including any pending result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         and_p1  <= '0;
         or_p1   <= '0;
         nand_p1 <= '0;
         nor_p1  <= '0;
         notb_p1 <= '0;
         xor_p1  <= '0;
         xnor_p1 <= '0;
         vld_p1  <= 1'b0;
      end else begin
         vld_p1 <= in_valid;
         if (in_valid) begin
            and_p1  <= and_p0;
            or_p1   <= or_p0;
            nand_p1 <= nand_p0;
            nor_p1  <= nor_p0;
            notb_p1 <= notb_p0;
            xor_p1  <= xor_p0;
            xnor_p1 <= xnor_p0;
         end
      end
   end

   assign and_out   = and_p1;
   assign or_out    = or_p1;
   assign nand_out  = nand_p1;
   assign nor_out   = nor_p1;
   assign notb_out  = notb_p1;
   assign xor_out   = xor_p1;
   assign xnor_out  = xnor_p1;
   assign out_valid = vld_p1;
`else
   // The clock has no role when the outputs are combinational.
   logic unused_clk;
   assign unused_clk = clk;

   assign and_out   = and_p0;
   assign or_out    = or_p0;
   assign nand_out  = nand_p0;
   assign nor_out   = nor_p0;
   assign notb_out  = notb_p0;
   assign xor_out   = xor_p0;
   assign xnor_out  = xnor_p0;
   assign out_valid = in_valid & rst_n;
`endif

endmodule

// File: tb/tb_gate_logic_core.sv
// Directed bench for gate_logic_core at WIDTH=1 and WIDTH=8; follows the
// build's GATE_LOGIC_REG_OUT_EN setting to pick registered or combinational checks.
module tb_gate_logic_core;

  logic       clk = 1'b0;
  logic       clk_run = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic       a1 = 1'b0, b1 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;

  logic       and1, or1, nand1, nor1, notb1, xor1, xnor1, vld1;
  logic [7:0] and8, or8, nand8, nor8, notb8, xor8, xnor8;
  logic       vld8;

  logic [7:0]  w1_pack;
  logic [56:0] w8_pack;
  assign w1_pack = {and1, or1, nand1, nor1, notb1, xor1, xnor1, vld1};
  assign w8_pack = {and8, or8, nand8, nor8, notb8, xor8, xnor8, vld8};

  int checks = 0;
  int errors = 0;
  bit done = 1'b0;

  logic [7:0]  exp_row [4];
  logic [56:0] exp_w8;
  logic [2:0]  cnt;

  task automatic chk(input string tag, input logic [56:0] obs, input logic [56:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  gate_logic_core #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(in_valid),
    .and_out(and1), .or_out(or1), .nand_out(nand1), .nor_out(nor1),
    .notb_out(notb1), .xor_out(xor1), .xnor_out(xnor1), .out_valid(vld1)
  );

  gate_logic_core #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .in_valid(in_valid),
    .and_out(and8), .or_out(or8), .nand_out(nand8), .nor_out(nor8),
    .notb_out(notb8), .xor_out(xor8), .xnor_out(xnor8), .out_valid(vld8)
  );

  initial begin
    #100000;
    if (!done) begin
      errors++;
      $error("FAIL timeout: wait expired before test completion");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  initial begin
    // {and,or,nand,nor,notb,xor,xnor,valid} for {a,b} = 00,01,10,11
    exp_row[0] = 8'h3B;
    exp_row[1] = 8'h65;
    exp_row[2] = 8'h6D;
    exp_row[3] = 8'hC3;
    exp_w8 = {8'h05, 8'hAF, 8'hFA, 8'h50, 8'hF0, 8'hAA, 8'h55, 1'b1};

`ifdef GATE_LOGIC_REG_OUT_EN
    clk_run = 1'b1;
    rst_n = 1'b0;
    in_valid = 1'b1;
    a1 = 1'b1; b1 = 1'b1;
    a8 = 8'hFF; b8 = 8'hFF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset_w1", w1_pack, 57'h0);
    chk("reset_w8", w8_pack, 57'h0);

    rst_n = 1'b1;
    cnt = 3'd0;
    for (int i = 0; i < 5; i++) begin
      {a1, b1} = cnt[1:0];
      @(posedge clk); #1;
      chk("truth_row", w1_pack, exp_row[cnt[1:0]]);
      cnt = cnt + 3'd1;
    end

    a8 = 8'hA5; b8 = 8'h0F;
    @(posedge clk); #1;
    chk("w8_a5_0f", w8_pack, exp_w8);

    {a1, b1} = 2'b01;
    @(posedge clk); #1;
    chk("pulse_capture", w1_pack, 57'h65);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      {a1, b1} = 2'(i + 2);
      a8 = 8'h3C; b8 = 8'hC3;
      @(posedge clk); #1;
      chk("idle_hold_w1", w1_pack, 57'h64);
      chk("idle_hold_w8", w8_pack, exp_w8 & ~57'h1);
    end

    in_valid = 1'b1;
    {a1, b1} = 2'b11;
    @(posedge clk); #1;
    chk("pre_reset", w1_pack, 57'hC3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_w1", w1_pack, 57'h0);
    chk("async_reset_w8", w8_pack, 57'h0);
    @(posedge clk); #1;
    chk("reset_ignores_valid", w1_pack, 57'h0);
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("post_release_idle", w1_pack, 57'h0);
    in_valid = 1'b1;
    {a1, b1} = 2'b10;
    @(posedge clk); #1;
    chk("post_release_capture", w1_pack, 57'h6D);
`else
    rst_n = 1'b1;
    in_valid = 1'b1;
    cnt = 3'd0;
    for (int i = 0; i < 5; i++) begin
      {a1, b1} = cnt[1:0];
      #1;
      chk("comb_row", w1_pack, exp_row[cnt[1:0]]);
      cnt = cnt + 3'd1;
    end
    in_valid = 1'b0;
    {a1, b1} = 2'b10;
    #1;
    chk("comb_valid_low", w1_pack, 57'h6C);
    in_valid = 1'b1;
    {a1, b1} = 2'b11;
    #1;
    chk("comb_valid_high", w1_pack, 57'hC3);
    a8 = 8'hA5; b8 = 8'h0F;
    #1;
    chk("comb_w8", w8_pack, exp_w8);
    rst_n = 1'b0;
    #1;
    chk("comb_reset_w1", w1_pack, 57'hC2);
    chk("comb_reset_w8", w8_pack, exp_w8 & ~57'h1);
    {a1, b1} = 2'b01;
    #1;
    chk("comb_reset_follow", w1_pack, 57'h64);
    rst_n = 1'b1;
    #1;
    chk("comb_release", w1_pack, 57'h65);
`endif

    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
